// File: rtl/regfile_bist.sv
// March-test BIST controller for a 32x32 two-read/one-write register file.
// Idle: host controls pass straight through; busy: controller drives the register file.
`timescale 1ns/1ps
module regfile_bist (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [4:0]  FailAddr,
  output logic [1:0]  FailPort,
  input  logic [31:0] HostWriteData,
  input  logic [4:0]  HostWriteRegister,
  input  logic [4:0]  HostReadRegister1,
  input  logic [4:0]  HostReadRegister2,
  input  logic        HostRegWrite,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  output logic        RegWrite,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2
);

  typedef enum logic [2:0] {IDLE, WA, RA, WB, RB, DONE} state_t;

  state_t      state;
  logic [4:0]  a;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_addr;
  logic [1:0]  fail_port;
  logic [31:0] exp1;
  logic [31:0] exp2;
  logic        mis1;
  logic        mis2;

  function automatic logic [31:0] pat_a(input logic [4:0] addr);
    return 32'hA5A5A500 | {27'd0, addr};
  endfunction

  function automatic logic [31:0] pat_b(input logic [4:0] addr);
    return ~pat_a(addr);
  endfunction

  // Register 0 always reads back as zero, whatever pattern was written.
  function automatic logic [31:0] expected(input logic [4:0] addr, input logic use_b);
    logic [31:0] v;
    if (addr == 5'd0) begin
      v = 32'd0;
    end else if (use_b) begin
      v = pat_b(addr);
    end else begin
      v = pat_a(addr);
    end
    return v;
  endfunction

  // Read comparison; only feeds the state register, never an output.
  always_comb begin
    exp1 = expected(a, state == RB);
    exp2 = expected(~a, state == RB);
    mis1 = (ReadData1 != exp1);
    mis2 = (ReadData2 != exp2);
  end

  // Register-file drive: host pass-through when idle, decoded from state/a when testing.
  always_comb begin
    WriteData     = HostWriteData;
    WriteRegister = HostWriteRegister;
    ReadRegister1 = HostReadRegister1;
    ReadRegister2 = HostReadRegister2;
    RegWrite      = HostRegWrite;
    case (state)
      WA, RA, WB, RB: begin
        WriteRegister = a;
        ReadRegister1 = a;
        ReadRegister2 = ~a;
        RegWrite      = (state == WA) || (state == WB);
        WriteData     = ((state == WA) || (state == RB)) ? pat_a(a) : pat_b(a);
      end
      default: begin
        RegWrite = HostRegWrite;
      end
    endcase
  end

  // Test sequencer with registered status outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      a         <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= 5'd0;
      fail_port <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state     <= WA;
            a         <= 5'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= 5'd0;
            fail_port <= 2'd0;
          end
        end
        WA: begin
          a <= a + 5'd1;
          if (a == 5'd31) begin
            state <= RA;
          end
        end
        RA, RB: begin
          if (mis1 || mis2) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_port <= {mis2, mis1};
            fail_addr <= mis1 ? a : ~a;
          end else if (a == 5'd31) begin
            if (state == RA) begin
              state <= WB;
              a     <= 5'd31;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end else begin
            a <= a + 5'd1;
          end
        end
        WB: begin
          a <= a - 5'd1;
          if (a == 5'd0) begin
            state <= RB;
            a     <= 5'd0;
          end
        end
        default: begin
          state <= IDLE;
          a     <= 5'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy     = busy;
  assign Done     = done;
  assign Pass     = pass;
  assign FailAddr = fail_addr;
  assign FailPort = fail_port;

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: a behavioural register file with selectable faults,
// and an array-level march reference deciding pass/fail and completion time.
`timescale 1ns/1ps
module tb_regfile_bist;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic        Pass;
  logic [4:0]  FailAddr;
  logic [1:0]  FailPort;
  logic [31:0] HostWriteData;
  logic [4:0]  HostWriteRegister;
  logic [4:0]  HostReadRegister1;
  logic [4:0]  HostReadRegister2;
  logic        HostRegWrite;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int n_cmp;
  int n_bad;
  // 0 good, 1 write enable ignored, 2 every write hits all regs, 3 r0 is a real register, 4 port 2 stuck on r17
  int fault;
  logic [31:0] rf [32];

  regfile_bist dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Busy(Busy), .Done(Done), .Pass(Pass),
    .FailAddr(FailAddr), .FailPort(FailPort),
    .HostWriteData(HostWriteData), .HostWriteRegister(HostWriteRegister),
    .HostReadRegister1(HostReadRegister1), .HostReadRegister2(HostReadRegister2),
    .HostRegWrite(HostRegWrite),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2), .RegWrite(RegWrite),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic bit hits(input int f, input bit we, input int wa, input int i);
    if (i == 0 && f != 3) return 1'b0;
    case (f)
      1: return i == wa;
      2: return we;
      default: return we && (i == wa);
    endcase
  endfunction

  // Register file under test, possibly faulty.
  always @(posedge Clk) begin
    for (int i = 0; i < 32; i++)
      if (hits(fault, RegWrite, int'(WriteRegister), i)) rf[i] <= WriteData;
  end

  always_comb begin
    ReadData1 = rf[ReadRegister1];
    if (ReadRegister1 == 5'd0 && fault != 3) ReadData1 = 32'd0;
    ReadData2 = rf[ReadRegister2];
    if (fault == 4) ReadData2 = rf[17];
    else if (ReadRegister2 == 5'd0 && fault != 3) ReadData2 = 32'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] pat_a(input int x);
    return 32'hA5A5A500 | 32'(x & 31);
  endfunction

  function automatic logic [31:0] expv(input int x, input bit b);
    if (x == 0) return 32'd0;
    return b ? ~pat_a(x) : pat_a(x);
  endfunction

  // Run the march over a copy of the current array; report verdict and edges-to-Done.
  task automatic march_model(output bit pass, output int faddr, output int fport, output int ncyc);
    logic [31:0] m [32];
    logic [31:0] r1, r2, e1, e2, wd;
    int addr, ea;
    bit we;
    for (int j = 0; j < 32; j++) m[j] = rf[j];
    pass = 1'b1; faddr = 0; fport = 0; ncyc = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 32; i++) begin
        addr = (ph == 2) ? 31 - i : i;
        wd = (ph == 0 || ph == 3) ? pat_a(addr) : ~pat_a(addr);
        we = (ph == 0 || ph == 2);
        ncyc++;
        if (ph == 1 || ph == 3) begin
          r1 = (addr == 0 && fault != 3) ? 32'd0 : m[addr];
          ea = (fault == 4) ? 17 : 31 - addr;
          r2 = (ea == 0 && fault != 3) ? 32'd0 : m[ea];
          e1 = expv(addr, ph == 3);
          e2 = expv(31 - addr, ph == 3);
          if (r1 != e1 || r2 != e2) begin
            pass  = 1'b0;
            fport = ((r2 != e2) ? 2 : 0) + ((r1 != e1) ? 1 : 0);
            faddr = (r1 != e1) ? addr : 31 - addr;
            return;
          end
        end
        for (int j = 0; j < 32; j++)
          if (hits(fault, we, addr, j)) m[j] = wd;
      end
    end
  endtask

  task automatic rand_host();
    HostWriteData     = $urandom;
    HostWriteRegister = 5'($urandom_range(0, 31));
    HostReadRegister1 = 5'($urandom_range(0, 31));
    HostReadRegister2 = 5'($urandom_range(0, 31));
    HostRegWrite      = 1'($urandom_range(0, 1));
  endtask

  task automatic check_passthrough(input string tag);
    check({tag, "_wd"}, WriteData, HostWriteData);
    check({tag, "_wr"}, {27'd0, WriteRegister}, {27'd0, HostWriteRegister});
    check({tag, "_rr1"}, {27'd0, ReadRegister1}, {27'd0, HostReadRegister1});
    check({tag, "_rr2"}, {27'd0, ReadRegister2}, {27'd0, HostReadRegister2});
    check({tag, "_we"}, {31'd0, RegWrite}, {31'd0, HostRegWrite});
  endtask

  task automatic run_test(input int f, input int mid, input int rst_cyc, input bit plan,
                          input bit p_pass, input int p_addr, input int p_port, input int p_ncyc);
    bit m_pass;
    int m_addr, m_port, m_ncyc, ph, i;
    fault = f;
    repeat (4) begin
      @(negedge Clk);
      rand_host();
      #1;
      check_passthrough("idle");
      check("idle_busy", {31'd0, Busy}, 32'd0);
    end
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    march_model(m_pass, m_addr, m_port, m_ncyc);
    check("start_clear", {25'd0, Pass, FailAddr, FailPort}, 32'd0);
    for (int c = 0; c <= 200; c++) begin
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        check("rst_busy", {30'd0, Busy, Done}, 32'd0);
        check("rst_status", {25'd0, Pass, FailAddr, FailPort}, 32'd0);
        check_passthrough("rst");
        Reset_n = 1'b1;
        return;
      end
      if (plan && c == p_ncyc - 1) check("plan_done_early", {31'd0, Done}, 32'd0);
      if (plan && c == p_ncyc) check("plan_done_time", {31'd0, Done}, 32'd1);
      if (c < m_ncyc) begin
        ph = c / 32;
        i = c % 32;
        check("run_busy", {30'd0, Busy, Done}, 32'd2);
        check("run_we", {31'd0, RegWrite}, {31'd0, ph == 0 || ph == 2});
        check("run_wreg", {27'd0, WriteRegister}, (ph == 2) ? 31 - i : i);
        check("run_wdata", WriteData, (ph == 0 || ph == 3) ? pat_a(i) :
                                      (ph == 2) ? ~pat_a(31 - i) : ~pat_a(i));
        if (ph == 1 || ph == 3) begin
          check("run_rr1", {27'd0, ReadRegister1}, i);
          check("run_rr2", {27'd0, ReadRegister2}, 31 - i);
        end
      end else begin
        check("end_busy", {30'd0, Busy, Done}, 32'd1);
        check("end_pass", {31'd0, Pass}, {31'd0, m_pass});
        check("end_faddr", {27'd0, FailAddr}, m_addr);
        check("end_fport", {30'd0, FailPort}, m_port);
        if (plan) begin
          check("plan_pass", {31'd0, Pass}, {31'd0, p_pass});
          check("plan_faddr", {27'd0, FailAddr}, p_addr);
          check("plan_fport", {30'd0, FailPort}, p_port);
        end
        break;
      end
      rand_host();
      Start = (c == mid) ? 1'b1 : 1'b0;
      Reset_n = (c == rst_cyc) ? 1'b0 : 1'b1;
      @(negedge Clk);
    end
    Start = 1'b0;
    @(negedge Clk);
    rand_host();
    #1;
    check("hold_status", {28'd0, Done, Pass, FailPort}, {28'd0, 1'b1, m_pass, 2'(m_port)});
    check_passthrough("done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fault = 0;
    for (int j = 0; j < 32; j++) rf[j] = 32'd0;
    Reset_n = 1'b0;
    Start = 1'b0;
    rand_host();
    HostRegWrite = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_flags", {30'd0, Busy, Done}, 32'd0);
    check("reset_status", {25'd0, Pass, FailAddr, FailPort}, 32'd0);
    check_passthrough("reset");
    Reset_n = 1'b1;
    // host prefill with random data
    repeat (8) begin
      @(negedge Clk);
      rand_host();
      HostRegWrite = 1'b1;
    end
    @(negedge Clk);
    HostRegWrite = 1'b0;

    run_test(0, int'($urandom_range(5, 120)), -1, 1'b1, 1'b1, 0, 0, 128);
    @(negedge Clk);
    HostRegWrite = 1'b1; HostWriteRegister = 5'd2; HostWriteData = 32'd42;
    HostReadRegister1 = 5'd2; HostReadRegister2 = 5'd2;
    @(negedge Clk);
    HostRegWrite = 1'b0;
    #1;
    check("host_rd1", ReadData1, 32'd42);
    check("host_rd2", ReadData2, 32'd42);

    run_test(1, -1, -1, 1'b1, 1'b0, 15, 2, 49);
    run_test(2, -1, -1, 1'b1, 1'b0, 1, 3, 34);
    run_test(3, -1, -1, 1'b1, 1'b0, 0, 1, 33);
    run_test(4, -1, -1, 1'b1, 1'b0, 31, 2, 33);
    run_test(0, -1, 50, 1'b0, 1'b0, 0, 0, 0);
    repeat (3) run_test(int'($urandom_range(0, 4)), -1, -1, 1'b0, 1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
